// File: rtl/mem_stage.sv
// Memory-access pipeline stage: EX->MEM register, allow-in handshake,
// SRAM read-data capture across WB stalls, and load extension / forwarding.
module mem_stage (
  input  logic         clk,
  input  logic         reset,
  input  logic         EXreg_valid,
  input  logic         EX_ready_go,
  input  logic [109:0] EXreg_bus,
  output logic         MEM_allow_in,
  input  logic         WB_allow_in,
  input  logic [31:0]  data_sram_rdata,
  output logic         MEMreg_valid,
  output logic [69:0]  MEMreg_bus,
  output logic         MEM_rf_we,
  output logic [4:0]   MEM_rf_waddr,
  output logic [31:0]  MEM_rf_wdata
);

  logic         r_valid;
  logic [109:0] r_bus;
  logic         r_first;
  logic [31:0]  r_rdata_buf;

  logic         w_ready_go;
  logic         w_load;
  logic [2:0]   w_ld_op;
  logic [31:0]  w_alu_result;
  logic         w_rf_we;
  logic         w_res_from_mem;
  logic [4:0]   w_rf_waddr;
  logic [31:0]  w_pc;
  logic [31:0]  w_rdata;
  logic [7:0]   w_byte;
  logic [15:0]  w_half;
  logic [31:0]  w_load_ext;
  logic [31:0]  w_rf_wdata;
  logic         w_unused_bus;

  assign w_ready_go   = 1'b1;
  assign MEM_allow_in = !r_valid | (w_ready_go & WB_allow_in);
  assign w_load       = MEM_allow_in & EXreg_valid & EX_ready_go;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid     <= 1'b0;
      r_bus       <= '0;
      r_first     <= 1'b0;
      r_rdata_buf <= '0;
    end else begin
      if (MEM_allow_in) r_valid <= EXreg_valid & EX_ready_go;
      if (w_load)       r_bus   <= EXreg_bus;
      r_first <= w_load;
      // SRAM data is only valid in the first resident cycle; keep it for stalls
      if (r_first)      r_rdata_buf <= data_sram_rdata;
    end
  end

  assign w_ld_op        = r_bus[109:107];
  assign w_alu_result   = r_bus[106:75];
  assign w_rf_we        = r_bus[38];
  assign w_res_from_mem = r_bus[37];
  assign w_rf_waddr     = r_bus[36:32];
  assign w_pc           = r_bus[31:0];
  // rkd_value and mem_we are consumed at the SRAM request in EX, not here
  assign w_unused_bus   = ^r_bus[74:39];

  assign w_rdata = r_first ? data_sram_rdata : r_rdata_buf;
  assign w_half  = w_alu_result[1] ? w_rdata[31:16] : w_rdata[15:0];

  always_comb begin
    w_byte = w_rdata[7:0];
    case (w_alu_result[1:0])
      2'd1:    w_byte = w_rdata[15:8];
      2'd2:    w_byte = w_rdata[23:16];
      2'd3:    w_byte = w_rdata[31:24];
      default: w_byte = w_rdata[7:0];
    endcase
  end

  always_comb begin
    w_load_ext = w_rdata;
    case (w_ld_op)
      3'b001:  w_load_ext = {{24{w_byte[7]}}, w_byte};
      3'b010:  w_load_ext = {24'h0, w_byte};
      3'b011:  w_load_ext = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_ext = {16'h0, w_half};
      default: w_load_ext = w_rdata;
    endcase
  end

  assign w_rf_wdata = w_res_from_mem ? w_load_ext : w_alu_result;

  assign MEMreg_valid = r_valid & w_ready_go;
  assign MEMreg_bus   = {w_rf_we, w_rf_waddr, w_rf_wdata, w_pc};
  assign MEM_rf_we    = w_rf_we & r_valid;
  assign MEM_rf_waddr = w_rf_waddr;
  assign MEM_rf_wdata = w_rf_wdata;

endmodule
